tmma_seq: RTL
=============

Name: tmma_seq

Overview:
Per-tile sequencer for the PE systolic array. It accepts one TMMA command, then runs the tile through up to four phases: it preloads C accumulators over the left edge, streams K A/B operand beats into the left/top edges, waits for the wavefront to drain, and optionally issues store-C beats on the top edge. It drives the row-0/column-0 edge signals and the operand buffer read ports. Per-row and per-column skew is applied by a downstream skew stage, not by this block.

Parameters:
SARRAY_W, 8, array columns; C preload beats per tile
SARRAY_H, 8, array rows; store-C beats per tile
CNT_W, 8, width of cnt fields and cmd_k (matches TMMA_CNT_WIDTH)
PREC_W, 2, precision field width (matches TMMA_PRECISION_WIDTH)
ADDR_W, 8, operand buffer address width
MAC_LAT, 2, MAC pipeline latency in cycles

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  high only in IDLE
cmd_k_i  in  CNT_W  number of A/B beats (0 allowed)
cmd_precision_i  in  PREC_W  precision forwarded to the PEs
cmd_loadc_i  in  1  1: run the C preload phase
cmd_storec_i  in  1  1: run the store-C phase
cmd_a_base_i / cmd_b_base_i / cmd_c_base_i  in  ADDR_W each  buffer base addresses
a_rd_en_o, b_rd_en_o, c_rd_en_o  out  1 each  buffer read enables (read data returns next cycle)
a_rd_addr_o, b_rd_addr_o, c_rd_addr_o  out  ADDR_W each  read addresses
left_data_valid_o  out  1  left-edge beat valid
left_data_cnt_o  out  CNT_W  left-edge cnt
left_data_type_o  out  1  0 = type A, 1 = type C
left_precision_o  out  PREC_W  latched precision
top_data_valid_o  out  1  top-edge B beat valid
top_data_cnt_o  out  CNT_W  top-edge cnt
top_storec_valid_o  out  1  store-C beat
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle completion pulse

Behaviour:
- FSM states: IDLE, LOADC, MAC, DRAIN, STORE, DONE.
- Handshake:
  - A command is accepted on cmd_valid_i & cmd_ready_o.
  - On acceptance, latch all cmd fields and clear the index counter idx.
  - The next state is LOADC if loadc=1; else MAC if k!=0; else DRAIN.
- LOADC (SARRAY_W cycles, idx = 0..W-1):
  - c_rd_en=1, c_rd_addr = c_base + idx.
  - The left-edge beat follows one cycle later: valid=1, type=1, cnt = SARRAY_W - idx. The first beat carries cnt=W (captured by column 0); the last carries cnt=1.
  - At idx=W-1, go to MAC if k!=0, else DRAIN. idx is cleared.
- MAC (k cycles, idx = 0..k-1):
  - a_rd_en = b_rd_en = 1, addresses = base + idx (modulo 2^ADDR_W; wrap is permitted).
  - One cycle later: left valid=1, type=0, cnt=idx; top valid=1, cnt=idx.
  - The left and top beats are always simultaneous.
  - At idx=k-1, go to DRAIN.
- DRAIN: counts D = SARRAY_W + SARRAY_H + MAC_LAT cycles. The count starts in the cycle after the last edge beat, so the final registered beat still leaves normally. On expiry, go to STORE if storec=1, else DONE.
- STORE (SARRAY_H cycles):
  - top_storec_valid_o=1, top_data_cnt_o = idx.
  - top_data_valid_o=0 and all buffer reads are 0.
  - At idx=H-1, go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. cmd_ready_o stays 0 in DONE, so commands are never accepted back-to-back in the same cycle.
- Edge outputs are registered. Each valid is its rd_en delayed by one cycle, aligning it with buffer read data. cnt and type are delayed identically.
- left_precision_o holds the latched precision from acceptance until the next acceptance.
- Invariant: no left valid with type=0 without top valid, and no top valid outside MAC.
- Reset (any state, including mid-tile):
  - State returns to IDLE and counters clear.
  - All valid, rd_en, done and busy outputs are 0. cnt, addr, type and precision outputs are 0.
  - A beat in flight is dropped, not completed. The first command after reset is accepted in the cycle after rst falls.
- cmd_valid_i while busy is ignored (no latch). The requester holds its request until ready.

Test Plan:
- W=H=8: k=4, loadc=1, storec=0, c_base=0x10 → c_rd_addr 0x10..0x17; left cnt 8,7..1 with type=1; then 4 A/B beats cnt 0..3; done_o at 1+8+4+18 cycles after acceptance, i.e. cycle 31 ±1 for the output register.
- k=0, loadc=0, storec=1 → no rd_en ever; 18 drain cycles, then 8 storec beats cnt 0..7, then a single done pulse.
- a_base=0xFE, k=4 → a_rd_addr sequence 0xFE, 0xFF, 0x00, 0x01; left and top valid coincide in every beat.
- cmd_valid_i asserted continuously with changing fields → only the IDLE-cycle values are latched; cmd_ready_o=0 during busy and DONE.
- rst asserted during the MAC idx=2 beat → the next cycle shows all outputs 0 and IDLE; a new command runs from idx=0 unaffected.
- Precision=2 then precision=1 on consecutive tiles → left_precision_o switches exactly at the second acceptance.

Source files
------------

// File: rtl/tmma_seq.sv
// tmma_seq: per-tile TMMA sequencer driving the systolic array edges and operand buffer reads.
module tmma_seq #(
  parameter int SARRAY_W = 8,
  parameter int SARRAY_H = 8,
  parameter int CNT_W = 8,
  parameter int PREC_W = 2,
  parameter int ADDR_W = 8,
  parameter int MAC_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid_i,
  output logic cmd_ready_o,
  input  logic [CNT_W-1:0] cmd_k_i,
  input  logic [PREC_W-1:0] cmd_precision_i,
  input  logic cmd_loadc_i,
  input  logic cmd_storec_i,
  input  logic [ADDR_W-1:0] cmd_a_base_i,
  input  logic [ADDR_W-1:0] cmd_b_base_i,
  input  logic [ADDR_W-1:0] cmd_c_base_i,
  output logic a_rd_en_o,
  output logic b_rd_en_o,
  output logic c_rd_en_o,
  output logic [ADDR_W-1:0] a_rd_addr_o,
  output logic [ADDR_W-1:0] b_rd_addr_o,
  output logic [ADDR_W-1:0] c_rd_addr_o,
  output logic left_data_valid_o,
  output logic [CNT_W-1:0] left_data_cnt_o,
  output logic left_data_type_o,
  output logic [PREC_W-1:0] left_precision_o,
  output logic top_data_valid_o,
  output logic [CNT_W-1:0] top_data_cnt_o,
  output logic top_storec_valid_o,
  output logic busy_o,
  output logic done_o
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LOADC = 3'd1, S_MAC = 3'd2, S_DRAIN = 3'd3, S_STORE = 3'd4, S_DONE = 3'd5;
  localparam int D = SARRAY_W + SARRAY_H + MAC_LAT;
  logic [2:0] state;
  logic [CNT_W-1:0] idx, k;
  logic loadc, storec, c_en, ab_en, st_en, last;
  logic [ADDR_W-1:0] a_base, b_base, c_base;
  assign c_en = state == S_LOADC;
  assign ab_en = state == S_MAC;
  assign st_en = state == S_STORE;
  assign last = (c_en && idx == CNT_W'(SARRAY_W - 1)) || (ab_en && idx == k - 1'b1) ||
                (state == S_DRAIN && idx == CNT_W'(D - 1)) || (st_en && idx == CNT_W'(SARRAY_H - 1));
  assign cmd_ready_o = state == S_IDLE;
  assign busy_o = state != S_IDLE;
  assign done_o = state == S_DONE;
  assign c_rd_en_o = c_en;
  assign a_rd_en_o = ab_en;
  assign b_rd_en_o = ab_en;
  assign c_rd_addr_o = c_en ? c_base + ADDR_W'(idx) : '0;
  assign a_rd_addr_o = ab_en ? a_base + ADDR_W'(idx) : '0;
  assign b_rd_addr_o = ab_en ? b_base + ADDR_W'(idx) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx <= '0;
      k <= '0;
      loadc <= 1'b0;
      storec <= 1'b0;
      a_base <= '0;
      b_base <= '0;
      c_base <= '0;
      left_precision_o <= '0;
      left_data_valid_o <= 1'b0;
      left_data_cnt_o <= '0;
      left_data_type_o <= 1'b0;
      top_data_valid_o <= 1'b0;
      top_data_cnt_o <= '0;
      top_storec_valid_o <= 1'b0;
    end else begin
      // Edge beats trail their buffer reads by one cycle to line up with read data.
      left_data_valid_o <= c_en || ab_en;
      left_data_type_o <= c_en;
      left_data_cnt_o <= c_en ? CNT_W'(SARRAY_W) - idx : ab_en ? idx : '0;
      top_data_valid_o <= ab_en;
      top_data_cnt_o <= (ab_en || st_en) ? idx : '0;
      top_storec_valid_o <= st_en;
      idx <= (last || state == S_IDLE || state == S_DONE) ? '0 : idx + 1'b1;
      case (state)
        S_IDLE: if (cmd_valid_i) begin
          k <= cmd_k_i;
          loadc <= cmd_loadc_i;
          storec <= cmd_storec_i;
          a_base <= cmd_a_base_i;
          b_base <= cmd_b_base_i;
          c_base <= cmd_c_base_i;
          left_precision_o <= cmd_precision_i;
          state <= cmd_loadc_i ? S_LOADC : cmd_k_i != '0 ? S_MAC : S_DRAIN;
        end
        S_LOADC: if (last) state <= k != '0 ? S_MAC : S_DRAIN;
        S_MAC: if (last) state <= S_DRAIN;
        S_DRAIN: if (last) state <= storec ? S_STORE : S_DONE;
        S_STORE: if (last) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
